lif_neuron: RTL and testbench

Leaky integrate-and-fire neuron stage that sits directly downstream of the 25-input spike/weight MAC. Each valid timestep it consumes the MAC's registered 21-bit weighted sum and integrates it into a leaking membrane potential. It emits a one-cycle output spike when the potential reaches threshold, then holds off for a refractory period. It also keeps a per-image spike count used by the classification logic.

---
 rtl/lif_neuron.sv | 103 ++++++++++
 tb/tb_lif_neuron.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates MAC sums into a leaking, saturating potential and fires on threshold.
// Build option: define LIF_SOFT_RESET_EN for subtractive post-spike reset (default is hard reset to zero).
module lif_neuron #(
   parameter int SUM_WIDTH      = 21,
   parameter int POT_WIDTH      = 24,
   parameter int THRESHOLD      = 20000,
   parameter int LEAK_SHIFT     = 3,
   parameter int REFRACT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [SUM_WIDTH-1:0] sumIn,
   input  logic                 sumValid,
   input  logic                 clear,
   output logic                 spikeOut,
   output logic [POT_WIDTH-1:0] membraneOut,
   output logic                 refractory,
   output logic [15:0]          spikeCount
);

   localparam int                RC_W       = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
   localparam logic [POT_WIDTH:0] THRESH_EXT = (POT_WIDTH + 1)'(THRESHOLD);
   localparam logic [POT_WIDTH:0] POT_MAX    = {1'b0, {POT_WIDTH{1'b1}}};
   localparam logic [RC_W-1:0]    RC_LOAD    = RC_W'(REFRACT_CYCLES);

   typedef enum logic {INTEG, REFRACT} state_t;

   state_t               state, state_next;
   logic [POT_WIDTH-1:0] v, v_next, v_spike, leak;
   logic [POT_WIDTH:0]   vn_raw, vn_sat;
   logic [RC_W-1:0]      rc, rc_next;
   logic [15:0]          count, count_next;
   logic                 spike_next;

   // One extra bit catches overflow of v - leak + sumIn before saturating.
   always_comb begin
      leak    = (LEAK_SHIFT == 0) ? '0 : (v >> LEAK_SHIFT);
      vn_raw  = {1'b0, v} - {1'b0, leak} + (POT_WIDTH + 1)'(sumIn);
      vn_sat  = vn_raw[POT_WIDTH] ? POT_MAX : vn_raw;
`ifdef LIF_SOFT_RESET_EN
      v_spike = POT_WIDTH'(vn_sat - THRESH_EXT);
`else
      v_spike = '0;
`endif
   end

   // NOTE: every signal gets a default before any branch so no latch is inferred.
   always_comb begin
      state_next = state;
      v_next     = v;
      rc_next    = rc;
      count_next = count;
      spike_next = 1'b0;
      if (clear) begin
         state_next = INTEG;
         v_next     = '0;
         rc_next    = '0;
         count_next = '0;
      end else if (sumValid) begin
         unique case (state)
            INTEG: begin
               if (vn_sat >= THRESH_EXT) begin
                  spike_next = 1'b1;
                  v_next     = v_spike;
                  if (count != 16'hFFFF) count_next = count + 16'd1;
                  if (REFRACT_CYCLES > 0) begin
                     rc_next    = RC_LOAD;
                     state_next = REFRACT;
                  end
               end else begin
                  v_next = vn_sat[POT_WIDTH-1:0];
               end
            end
            REFRACT: begin
               rc_next = rc - RC_W'(1);
               if (rc <= RC_W'(1)) state_next = INTEG;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INTEG;
         v        <= '0;
         rc       <= '0;
         count    <= '0;
         spikeOut <= 1'b0;
      end else begin
         state    <= state_next;
         v        <= v_next;
         rc       <= rc_next;
         count    <= count_next;
         spikeOut <= spike_next;
      end
   end

   assign membraneOut = v;
   assign spikeCount  = count;
   assign refractory  = (state == REFRACT);

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron: behavioural model compared every cycle, plus literal scenario checks.
module tb_lif_neuron;

   localparam longint TH   = 20000;
   localparam int     LS   = 3;
   localparam longint RCY  = 2;
   localparam longint MAXV = (64'd1 << 24) - 1;
`ifdef LIF_SOFT_RESET_EN
   localparam bit SOFT = 1'b1;
`else
   localparam bit SOFT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, clear, sumValid;
   logic [20:0] sumIn;
   logic        spikeOut, refractory;
   logic [23:0] membraneOut;
   logic [15:0] spikeCount;

   logic        s_rst, s_valid;
   logic [20:0] s_sum;
   logic        s_spike, s_refr;
   logic [23:0] s_mem;
   logic [15:0] s_count;

   int     n_tests = 0;
   int     n_fail  = 0;
   bit     chk_en  = 1'b0;

   longint m_v, m_rc, m_cnt;
   bit     m_spk;

   always #5 clk = ~clk;

   lif_neuron dut (
      .clk(clk), .rst(rst), .sumIn(sumIn), .sumValid(sumValid), .clear(clear),
      .spikeOut(spikeOut), .membraneOut(membraneOut), .refractory(refractory), .spikeCount(spikeCount)
   );

   lif_neuron #(.THRESHOLD(16777215), .LEAK_SHIFT(0)) u_sat (
      .clk(clk), .rst(s_rst), .sumIn(s_sum), .sumValid(s_valid), .clear(1'b0),
      .spikeOut(s_spike), .membraneOut(s_mem), .refractory(s_refr), .spikeCount(s_count)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: refractory is just "timesteps left to ignore > 0".
   task automatic model_step(input bit r, input bit c, input bit vld, input longint s);
      longint vn;
      m_spk = 1'b0;
      if (r || c) begin
         m_v = 0; m_rc = 0; m_cnt = 0;
      end else if (vld) begin
         if (m_rc > 0) begin
            m_rc = m_rc - 1;
         end else begin
            vn = m_v - ((LS == 0) ? 0 : (m_v >> LS)) + s;
            if (vn > MAXV) vn = MAXV;
            if (vn >= TH) begin
               m_spk = 1'b1;
               m_v   = SOFT ? vn - TH : 0;
               if (m_cnt < 65535) m_cnt = m_cnt + 1;
               m_rc  = RCY;
            end else begin
               m_v = vn;
            end
         end
      end
   endtask

   task automatic step(input bit r, input bit c, input bit vld, input int s);
      #1;
      rst = r; clear = c; sumValid = vld; sumIn = s[20:0];
      model_step(r, c, vld, longint'(s[20:0]));
      @(negedge clk);
   endtask

   task automatic sat_step(input bit r, input bit vld, input int s);
      #1;
      s_rst = r; s_valid = vld; s_sum = s[20:0];
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_spikeOut",    longint'(spikeOut),    longint'(m_spk));
         check("model_membraneOut", longint'(membraneOut), m_v);
         check("model_refractory",  longint'(refractory),  longint'(m_rc > 0));
         check("model_spikeCount",  longint'(spikeCount),  m_cnt);
      end
   end

   initial begin
      rst = 1'b1; clear = 1'b0; sumValid = 1'b0; sumIn = '0;
      s_rst = 1'b1; s_valid = 1'b0; s_sum = '0;
      m_v = 0; m_rc = 0; m_cnt = 0; m_spk = 1'b0;
      chk_en = 1'b1;

      step(1, 0, 0, 0);
      step(1, 0, 1, 5000);
      check("reset_spike", longint'(spikeOut), 0);
      check("reset_mem",   longint'(membraneOut), 0);
      check("reset_refr",  longint'(refractory), 0);
      check("reset_count", longint'(spikeCount), 0);

      step(0, 0, 1, 16000);
      check("integ_mem",   longint'(membraneOut), 16000);
      check("integ_spike", longint'(spikeOut), 0);
      step(0, 0, 1, 8000);
      check("fire_spike", longint'(spikeOut), 1);
      check("fire_mem",   longint'(membraneOut), SOFT ? 2000 : 0);
      check("fire_refr",  longint'(refractory), 1);
      check("fire_count", longint'(spikeCount), 1);
      step(0, 0, 0, 0);
      check("pulse_one_cycle", longint'(spikeOut), 0);

      step(0, 0, 1, 50000);
      check("refr1_mem",  longint'(membraneOut), SOFT ? 2000 : 0);
      check("refr1_refr", longint'(refractory), 1);
      step(0, 0, 1, 50000);
      check("refr2_refr",  longint'(refractory), 0);
      check("refr2_spike", longint'(spikeOut), 0);
      step(0, 0, 1, 50000);
      check("refr_exit_spike", longint'(spikeOut), 1);
      check("refr_exit_count", longint'(spikeCount), 2);

      step(0, 1, 1, 30000);
      check("clear_mem",   longint'(membraneOut), 0);
      check("clear_count", longint'(spikeCount), 0);
      check("clear_refr",  longint'(refractory), 0);
      check("clear_spike", longint'(spikeOut), 0);
      step(0, 0, 1, 30000);
      check("post_clear_spike", longint'(spikeOut), 1);
      check("post_clear_mem",   longint'(membraneOut), SOFT ? 10000 : 0);

      step(0, 1, 0, 0);
      step(0, 0, 1, 16000);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
      check("gap_hold_mem", longint'(membraneOut), 16000);
      step(0, 0, 1, 0);
      check("leak_mem", longint'(membraneOut), 14000);

      for (int i = 0; i < 3000; i++) begin
         bit r, c, vld;
         int s;
         r   = ($urandom_range(0, 199) == 0);
         c   = ($urandom_range(0, 49) == 0);
         vld = ($urandom_range(0, 9) < 7);
         s   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2097151)) : int'($urandom_range(0, 9000));
         step(r, c, vld, s);
      end

      step(0, 0, 0, 0);
      sat_step(1, 0, 0);
      for (int i = 0; i < 8; i++) sat_step(0, 1, 2097151);
      check("sat_accum_mem",   longint'(s_mem), 16777208);
      check("sat_accum_spike", longint'(s_spike), 0);
      sat_step(0, 1, 2097151);
      check("sat_fire_spike", longint'(s_spike), 1);
      check("sat_fire_mem",   longint'(s_mem), 0);
      check("sat_fire_count", longint'(s_count), 1);
      check("sat_fire_refr",  longint'(s_refr), 1);

      #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
